// File: rtl/wb_write_sequencer_pkg.sv
// Processor-wide definitions shared by the register file and the writeback
// write sequencer.
//   SP_OP_*       : encodings of the wb_sp_op stack-pointer adjustment field
//   RF_SP_ADDR    : register index that holds the stack pointer (R3)
//   RF_SP_RESET   : stack pointer value after reset (matches R3 reset value)
//   wb_seq_state_t: write sequencer FSM states
package wb_write_sequencer_pkg;

  localparam logic [1:0] SP_OP_NONE = 2'b00;
  localparam logic [1:0] SP_OP_INC  = 2'b01;
  localparam logic [1:0] SP_OP_DEC  = 2'b10;
  localparam logic [1:0] SP_OP_RSVD = 2'b11;

  localparam int unsigned RF_SP_ADDR  = 3;
  localparam logic [7:0]  RF_SP_RESET = 8'hFF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SP_PEND = 1'b1
  } wb_seq_state_t;

endpackage

// File: rtl/wb_write_sequencer.sv
// Writeback write sequencer: sole driver of the register file's single write
// port. Stack instructions that need both a destination write and an SP (R3)
// update are split into two back-to-back register-file writes; upstream is
// stalled for the second one. A shadow SP is kept so consecutive stack ops
// never see a stale value.
//
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-low reset
//   wb_valid / wb_ready  : upstream request handshake
//   wb_we, wb_rd, wb_data: primary register write carried by the request
//   wb_sp_op             : 00 none, 01 SP+1, 10 SP-1, 11 reserved (= none)
//   rf_wr_en/addr/data   : registered register-file write port
//   sp_value             : current shadow SP (stack address for MEM)
//   busy                 : FSM state, high in ST_SP_PEND (deferred SP write)
//
// Handshake: a request is taken at a rising edge where wb_valid and wb_ready
// are both high; request fields are only looked at on that edge. wb_ready is
// a pure function of the FSM state, so it never depends on wb_valid.
module wb_write_sequencer
  import wb_write_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned SP_ADDR  = RF_SP_ADDR,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(RF_SP_RESET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        wb_sp_op,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] sp_value,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(SP_ADDR);

  wb_seq_state_t     state;
  logic [DATA_W-1:0] sp_shadow;
  logic [DATA_W-1:0] sp_pending;

  logic              accept;
  logic              sp_step;
  logic [DATA_W-1:0] sp_new;

  assign wb_ready = (state == ST_IDLE);
  assign busy     = (state == ST_SP_PEND);
  assign sp_value = sp_shadow;
  assign accept   = wb_valid && wb_ready;

  // Reserved encoding is treated as "no SP change".
  assign sp_step = (wb_sp_op == SP_OP_INC) || (wb_sp_op == SP_OP_DEC);
  // Always derived from the shadow as it stands at the accept edge; wraps
  // naturally modulo 2^DATA_W.
  assign sp_new  = (wb_sp_op == SP_OP_INC) ? sp_shadow + DATA_W'(1)
                                           : sp_shadow - DATA_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sp_shadow  <= SP_RESET;
      sp_pending <= '0;
      rf_wr_en   <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rf_wr_en <= 1'b0;
          if (accept) begin
            if (wb_we) begin
              rf_wr_en <= 1'b1;
              rf_addr  <= wb_rd;
              rf_data  <= wb_data;
              if (sp_step) begin
                // SP write is deferred one cycle; it lands after the primary
                // write, so it wins even when wb_rd is the SP register.
                sp_pending <= sp_new;
                state      <= ST_SP_PEND;
              end else if (wb_rd == SP_IDX) begin
                sp_shadow <= wb_data;
              end
            end else if (sp_step) begin
              rf_wr_en  <= 1'b1;
              rf_addr   <= SP_IDX;
              rf_data   <= sp_new;
              sp_shadow <= sp_new;
            end
          end
        end
        ST_SP_PEND: begin
          rf_wr_en  <= 1'b1;
          rf_addr   <= SP_IDX;
          rf_data   <= sp_pending;
          sp_shadow <= sp_pending;
          state     <= ST_IDLE;
        end
        default: begin
          rf_wr_en <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer. The driver issues requests, a request-level
// model of the stack pointer predicts the register-file writes (cycle,
// address, data, SP seen alongside) and queues them; a monitor compares every
// write the DUT presents against the head of that queue.
module tb_wb_write_sequencer;

  localparam int EW = 34; // {cyc[15:0], addr[1:0], data[7:0], sp[7:0]}

  logic       clk;
  logic       rst;
  logic       wb_valid;
  logic       wb_ready;
  logic       wb_we;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic [1:0] wb_sp_op;
  logic       rf_wr_en;
  logic [1:0] rf_addr;
  logic [7:0] rf_data;
  logic [7:0] sp_value;
  logic       busy;

  wb_write_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_sp_op (wb_sp_op),
    .rf_wr_en (rf_wr_en),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .sp_value (sp_value),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  logic [7:0] m_sp = 8'hFF;
  int         stall_cyc = -1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [EW-1:0] pack(input int c, input logic [1:0] a,
                                         input logic [7:0] d, input logic [7:0] s);
    logic [15:0] c16;
    c16 = 16'(c);
    return {c16, a, d, s};
  endfunction

  // Request-level model: called when the request is accepted at edge cyc+1.
  task automatic model_accept(input logic we, input logic [1:0] rd,
                              input logic [7:0] data, input logic [1:0] op);
    logic       step;
    logic [7:0] nsp;
    step = (op == 2'b01) || (op == 2'b10);
    nsp  = (op == 2'b01) ? m_sp + 8'd1 : m_sp - 8'd1;
    if (we && step) begin
      exp_q.push_back(pack(cyc + 1, rd, data, m_sp));
      exp_q.push_back(pack(cyc + 2, 2'd3, nsp, nsp));
      m_sp      = nsp;
      stall_cyc = cyc + 1;
    end else if (we) begin
      if (rd == 2'd3) m_sp = data;
      exp_q.push_back(pack(cyc + 1, rd, data, m_sp));
    end else if (step) begin
      m_sp = nsp;
      exp_q.push_back(pack(cyc + 1, 2'd3, nsp, nsp));
    end
  endtask

  task automatic check_ready();
    check("wb_ready", wb_ready, (cyc != stall_cyc));
    check("busy", busy, (cyc == stall_cyc));
  endtask

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic send(input logic we, input logic [1:0] rd,
                      input logic [7:0] data, input logic [1:0] op);
    int tries;
    wb_valid = 1'b1; wb_we = we; wb_rd = rd; wb_data = data; wb_sp_op = op;
    tries = 0;
    forever begin
      check_ready();
      if (wb_ready === 1'b1) begin
        model_accept(we, rd, data, op);
        @(negedge clk);
        break;
      end
      tries++;
      if (tries > 4) begin
        check("accept_timeout", 32'(tries), 32'd0);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    wb_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    wb_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_ready();
      @(negedge clk);
    end
  endtask

  // Asynchronous reset pulse placed away from both clock edges.
  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    exp_q.delete();
    m_sp      = 8'hFF;
    stall_cyc = -1;
    #1;
    check("rst_rf_wr_en", rf_wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sp_value", sp_value, 8'hFF);
    check("rst_wb_ready", wb_ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rf_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {22'd0, rf_addr, rf_data}, 32'hFFFF_FFFF);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("write_cycle", 32'(cyc[15:0]), 32'(e[33:18]));
          check("rf_addr", rf_addr, e[17:16]);
          check("rf_data", rf_data, e[15:8]);
          check("sp_value", sp_value, e[7:0]);
        end
      end else if (exp_q.size() != 0) begin
        logic [EW-1:0] e;
        e = exp_q[0];
        if (32'(cyc[15:0]) >= 32'(e[33:18])) begin
          check("write_present", rf_wr_en, 1'b1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_rd = '0;
    wb_data = '0; wb_sp_op = '0;
    #3 rst = 1'b0;
    #1;
    check("init_rf_wr_en", rf_wr_en, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_sp_value", sp_value, 8'hFF);
    check("init_wb_ready", wb_ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // plain write
    send(1'b1, 2'd1, 8'h5A, 2'b00);
    idle(1);
    // two PUSHes from reset SP: FE then FD
    send(1'b0, 2'd0, 8'h00, 2'b10);
    send(1'b0, 2'd0, 8'h00, 2'b10);
    idle(1);
    pulse_reset();
    // POP with SP=FF: R2=33 then R3=00, next request held through the stall
    send(1'b1, 2'd2, 8'h33, 2'b01);
    send(1'b1, 2'd0, 8'h77, 2'b00);
    // SP=00, decrement wraps to FF; reserved op writes nothing
    send(1'b0, 2'd0, 8'h00, 2'b10);
    send(1'b0, 2'd1, 8'h44, 2'b11);
    idle(2);
    // direct SP writes, and SP write racing a primary write to R3
    send(1'b1, 2'd3, 8'hAA, 2'b00);
    send(1'b0, 2'd0, 8'h00, 2'b01);
    send(1'b1, 2'd3, 8'h11, 2'b10);
    idle(2);
    // reset while the deferred SP write is pending
    send(1'b1, 2'd1, 8'h99, 2'b10);
    pulse_reset();
    idle(2);
    send(1'b0, 2'd0, 8'h00, 2'b10);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom), 2'($urandom_range(0, 3)));
    end
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
Writeback-stage block sitting directly upstream of the 4x8 register file's single write port (write address, write data, write enable).
It accepts one retired instruction's write request per handshake. Stack instructions (PUSH/POP/CALL/RET) need both a destination write and a stack-pointer (R3) update, so the block serializes these into two consecutive register-file writes and stalls upstream while doing so.
It keeps a shadow copy of SP so that back-to-back stack operations never read a stale SP.

Parameters:
DATA_W, 8, register/data width
ADDR_W, 2, register address width
SP_ADDR, 3, register index holding the stack pointer
SP_RESET, 8'hFF, SP value after reset; equal to the register file's R3 reset value

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
wb_valid  input  1  upstream request valid
wb_ready  output  1  block can accept a request this cycle
wb_we  input  1  request carries a primary register write
wb_rd  input  ADDR_W  primary destination register
wb_data  input  DATA_W  primary write data
wb_sp_op  input  2  00 none, 01 SP+1, 10 SP-1, 11 reserved (treated as none)
rf_wr_en  output  1  register-file write enable
rf_addr  output  ADDR_W  register-file write address
rf_data  output  DATA_W  register-file write data
sp_value  output  DATA_W  current shadow SP, used by MEM stage as stack address
busy  output  1  high while a deferred SP write is pending

Behaviour:
- Reset (async, rst=0): rf_wr_en=0, rf_addr=0, rf_data=0, busy=0, state=IDLE, sp_shadow=SP_RESET, so sp_value=8'hFF. Any pending SP write is dropped.
- States: IDLE, SP_PEND. wb_ready = (state==IDLE), combinational. busy = (state==SP_PEND).
- Accept = wb_valid & wb_ready sampled at a rising edge. Request fields are used only on accept.
- All rf_* outputs are registered. A write appears on rf_* during the cycle after the edge that produced it, and the register file commits it at the next edge.
- IDLE with accept, by case:
  - wb_we=1, sp_op none: drive rf_wr_en=1, rf_addr=wb_rd, rf_data=wb_data. Stay in IDLE.
  - wb_we=0, sp_op inc/dec: drive rf_wr_en=1, rf_addr=SP_ADDR, rf_data=sp_new. Set sp_shadow=sp_new. Stay in IDLE.
  - wb_we=1 with sp_op inc/dec: drive the primary write as above, latch sp_new into a pending register, go to SP_PEND.
  - wb_we=0, sp_op none (or reserved): drive rf_wr_en=0. Stay in IDLE.
- sp_new = sp_shadow +/- 1, modulo 2^8: 8'hFF+1=8'h00, 8'h00-1=8'hFF. It is always computed from sp_shadow at the accept edge, before any primary write.
- IDLE without accept: rf_wr_en=0. rf_addr and rf_data hold their previous values.
- SP_PEND, next edge (unconditional): drive rf_wr_en=1, rf_addr=SP_ADDR, rf_data=pending. Set sp_shadow=pending. Return to IDLE. wb_valid is ignored in this cycle.
- Throughput: single-write requests 1/cycle; dual-write requests 1 per 2 cycles.
- A primary write with wb_rd==SP_ADDR and no sp_op sets sp_shadow=wb_data at the same edge.
- A primary write with wb_rd==SP_ADDR and sp_op inc/dec:
  - the primary write is still issued;
  - the SP write follows and wins;
  - sp_shadow ends equal to pending.
- sp_shadow is valid only because this block is the sole writer of the register file. Nothing else may drive the write port.
- Reset asserted in SP_PEND: the deferred write is never issued; outputs take reset values immediately.

Decomposition:
- Shared package (processor-wide):
  - SP_OP_NONE/INC/DEC/RSVD encodings;
  - SP_ADDR and SP_RESET constants, so the register file and this block use one definition;
  - state enum {IDLE, SP_PEND}.
- No sub-module; the +/-1 SP adder is inline.

Test Plan:
- Reset -> rst low mid-cycle -> rf_wr_en=0, busy=0, sp_value=8'hFF, wb_ready=1 asynchronously.
- Accept {we=1, rd=1, data=8'h5A, sp_op=00} -> next cycle rf_wr_en=1, rf_addr=1, rf_data=8'h5A, wb_ready stays 1.
- From reset, PUSH {we=0, sp_op=10} -> rf write addr 3 data 8'hFE, sp_value=8'hFE. An immediately following PUSH writes 8'hFD, proving no stale SP.
- POP {we=1, rd=2, data=8'h33, sp_op=01} with SP=8'hFF:
  - cycle 1: rf write R2=8'h33, wb_ready=0, busy=1;
  - cycle 2: rf write R3=8'h00 (wrap), sp_value=8'h00;
  - a request held valid during the stall is accepted only after the stall.
- SP=8'h00, {we=0, sp_op=10} -> R3=8'hFF. sp_op=11 -> no write, SP unchanged.
- rst pulsed low while busy=1 -> no R3 write ever appears, sp_value=8'hFF, state IDLE.
